// File: rtl/seg_scan_pkg.sv
// Shared glyph table and helpers for the multiplexed 7-segment scan controller.
// Glyphs are active-low cathode patterns: bit7 = DP, [6:0] = g..a.
package seg_scan_pkg;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam int         DP_BIT  = 7;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_to_seg = SEG_0;
      4'h1:    hex_to_seg = SEG_1;
      4'h2:    hex_to_seg = SEG_2;
      4'h3:    hex_to_seg = SEG_3;
      4'h4:    hex_to_seg = SEG_4;
      4'h5:    hex_to_seg = SEG_5;
      4'h6:    hex_to_seg = SEG_6;
      4'h7:    hex_to_seg = SEG_7;
      4'h8:    hex_to_seg = SEG_8;
      4'h9:    hex_to_seg = SEG_9;
      4'hA:    hex_to_seg = SEG_A;
      4'hB:    hex_to_seg = SEG_B;
      4'hC:    hex_to_seg = SEG_C;
      4'hD:    hex_to_seg = SEG_D;
      4'hE:    hex_to_seg = SEG_E;
      default: hex_to_seg = SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment glyph (g..a), DP excluded.
module seg_hex_decoder
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = 7'(hex_to_seg(nibble));

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with double-buffered content,
// leading-zero suppression and PWM brightness. Define SEG_SCAN_BLINK_EN to build blinking.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DIGITS        = 8,
  parameter int SCAN_INTERVAL = 49999,
  parameter int BLINK_FRAMES  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [4*DIGITS-1:0]   i_data,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic [DIGITS-1:0]     i_blank,
  input  logic [DIGITS-1:0]     i_blink,
  input  logic                  i_lz_suppress,
  input  logic [2:0]            i_brightness,
  input  logic                  i_update,
  output logic                  o_update_ack,
  output logic                  o_frame_start,
  output logic [DIGITS-1:0]     o_seg_valid,
  output logic [7:0]            o_seg_value
);

  localparam int SLOT_W = (SCAN_INTERVAL > 0) ? $clog2(SCAN_INTERVAL + 1) : 1;
  localparam int DIG_W  = $clog2(DIGITS);
  localparam int ON_W   = SLOT_W + 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_INTERVAL);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(DIGITS - 1);

  // Lit cycles per slot for brightness b: ((b+1)*(SCAN_INTERVAL+1)) >> 3.
  function automatic logic [ON_W-1:0] duty_cycles(input logic [2:0] b);
    return ON_W'(((32'(b) + 32'd1) * (32'(SCAN_INTERVAL) + 32'd1)) >> 3);
  endfunction

  logic [SLOT_W-1:0]   slot;
  logic [DIG_W-1:0]    digit;
  logic [DIG_W-1:0]    bit_idx;
  logic [ON_W-1:0]     on_calc, on_hold, on_eff;
  logic                pending;
  logic                slot_end, frame_end, load;
  logic [4*DIGITS-1:0] sh_data;
  logic [DIGITS-1:0]   sh_dp, sh_blank;
  logic                sh_lz;
  logic [DIGITS-1:0]   blink_mask;
  logic [DIGITS-1:0]   lz_mask;
  logic                zero_run;
  logic [6:0]          glyph;
  logic [DIGITS-1:0]   anode_n;
  logic [7:0]          seg_n;

  assign slot_end  = (slot == SLOT_LAST);
  assign frame_end = slot_end && (digit == DIG_LAST);
  assign load      = frame_end && (pending || i_update);
  assign bit_idx   = DIG_LAST - digit;
  assign on_calc   = duty_cycles(i_brightness);
  assign on_eff    = (slot == '0) ? on_calc : on_hold;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot    <= '0;
      digit   <= '0;
      on_hold <= '0;
    end else begin
      if (slot == '0) on_hold <= on_calc;
      if (slot_end) begin
        slot  <= '0;
        digit <= (digit == DIG_LAST) ? '0 : digit + 1'b1;
      end else begin
        slot  <= slot + 1'b1;
      end
    end
  end

  // Shadow content only changes on a frame boundary so a frame never tears.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending  <= 1'b0;
      sh_data  <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
      sh_lz    <= 1'b0;
    end else if (load) begin
      pending  <= 1'b0;
      sh_data  <= i_data;
      sh_dp    <= i_dp;
      sh_blank <= i_blank;
      sh_lz    <= i_lz_suppress;
    end else if (i_update) begin
      pending  <= 1'b1;
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FRM_W-1:0]  frame_cnt;
  logic              blink_phase;
  logic [DIGITS-1:0] sh_blink;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      sh_blink    <= '0;
    end else begin
      if (load) sh_blink <= i_blink;
      if (frame_end) begin
        if (frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  assign blink_mask = blink_phase ? sh_blink : '0;
`else
  logic blink_unused;
  assign blink_unused = ^i_blink;
  assign blink_mask   = '0;
`endif

  // lz_mask is indexed by digit number; the last digit is never suppressed.
  always_comb begin
    zero_run = sh_lz;
    lz_mask  = '0;
    for (int k = 0; k < DIGITS - 1; k++) begin
      zero_run   = zero_run && (sh_data[4*(DIGITS-1-k) +: 4] == 4'h0);
      lz_mask[k] = zero_run;
    end
  end

  seg_hex_decoder u_dec (
    .nibble (sh_data[{bit_idx, 2'b00} +: 4]),
    .glyph  (glyph)
  );

  always_comb begin
    anode_n = '1;
    if ({1'b0, slot} < on_eff) anode_n[bit_idx] = 1'b0;
    seg_n         = SEG_OFF;
    seg_n[6:0]    = glyph;
    seg_n[DP_BIT] = ~sh_dp[bit_idx];
    if (lz_mask[digit]) seg_n[6:0] = 7'h7F;
    if (sh_blank[bit_idx] || blink_mask[bit_idx]) seg_n = SEG_OFF;
  end

  // Output register stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_seg_valid   <= '1;
      o_seg_value   <= SEG_OFF;
      o_update_ack  <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_seg_valid   <= anode_n;
      o_seg_value   <= seg_n;
      o_update_ack  <= load;
      o_frame_start <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=4, SCAN_INTERVAL=3, BLINK_FRAMES=2.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data;
  logic [3:0]  dp, blank, blink;
  logic        lz;
  logic [2:0]  bright;
  logic        update;
  logic        ack, fs;
  logic [3:0]  valid;
  logic [7:0]  value;

  int checks   = 0;
  int failures = 0;

  seg_scan_ctrl #(.DIGITS(4), .SCAN_INTERVAL(3), .BLINK_FRAMES(2)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_data        (data),
    .i_dp          (dp),
    .i_blank       (blank),
    .i_blink       (blink),
    .i_lz_suppress (lz),
    .i_brightness  (bright),
    .i_update      (update),
    .o_update_ack  (ack),
    .o_frame_start (fs),
    .o_seg_valid   (valid),
    .o_seg_value   (value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(valid), 32'hF);
    chk({tag, "_value"}, 32'(value), 32'hFF);
    chk({tag, "_ack"},   32'(ack),   32'h0);
    chk({tag, "_fs"},    32'(fs),    32'h0);
  endtask

  // Checks cycles j0..j0+n-1 of a frame; vals holds digit0..3 bytes MSB first.
  task automatic run_cycles(input int j0, input int n, input logic [31:0] vals,
                            input int on0, input int onr, input logic exp_ack);
    int d, s, on;
    logic [3:0] ev;
    logic [7:0] eval;
    for (int j = j0; j < j0 + n; j++) begin
      @(posedge clk); #1;
      d = j / 4;
      s = j % 4;
      on = (d == 0) ? on0 : onr;
      ev = 4'hF;
      if (s < on) ev[3-d] = 1'b0;
      eval = vals[31-8*d -: 8];
      chk($sformatf("valid_j%0d", j), 32'(valid), 32'(ev));
      chk($sformatf("value_j%0d", j), 32'(value), 32'(eval));
      chk($sformatf("fs_j%0d", j),    32'(fs),    32'(j == 15));
      chk($sformatf("ack_j%0d", j),   32'(ack),   (j == 15) ? 32'(exp_ack) : 32'h0);
    end
  endtask

  task automatic wait_fs(input logic exp_ack);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!fs && n < 40);
    chk("fs_wait", 32'(fs), 32'h1);
    chk("fs_ack",  32'(ack), 32'(exp_ack));
  endtask

  function automatic logic blink_off(input int f);
`ifdef SEG_SCAN_BLINK_EN
    return (f == 2 || f == 3 || f == 6 || f == 7);
`else
    return 1'b0;
`endif
  endfunction

  logic [31:0] v;
  logic        saw_ack;

  initial begin
    rst_n = 1'b0; data = 16'h0; dp = 4'h0; blank = 4'h0; blink = 4'h0;
    lz = 1'b0; bright = 3'd7; update = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");

    // Reset release and first load of 12AF
    data = 16'h12AF;
    @(negedge clk);
    rst_n = 1'b1;
    update = 1'b1;
    @(posedge clk); #1;
    chk("first_valid", 32'(valid), 32'h7);
    chk("first_value", 32'(value), 32'hC0);
    update = 1'b0;
    wait_fs(1'b1);
    run_cycles(0, 16, 32'hF9A4888E, 4, 4, 1'b0);

    // Leading-zero suppression with DP on digit 1
    data = 16'h00A0; lz = 1'b1; dp = 4'b0100; update = 1'b1;
    run_cycles(0, 1, 32'hF9A4888E, 4, 4, 1'b0);
    update = 1'b0;
    run_cycles(1, 15, 32'hF9A4888E, 4, 4, 1'b1);
    run_cycles(0, 16, 32'hFF7F88C0, 4, 4, 1'b0);

    // Brightness 0, 3, then a mid-slot change from 3 to 0
    bright = 3'd0;
    run_cycles(0, 16, 32'hFF7F88C0, 0, 0, 1'b0);
    bright = 3'd3;
    run_cycles(0, 16, 32'hFF7F88C0, 2, 2, 1'b0);
    run_cycles(0, 1, 32'hFF7F88C0, 2, 2, 1'b0);
    bright = 3'd0;
    run_cycles(1, 15, 32'hFF7F88C0, 2, 0, 1'b0);
    bright = 3'd7;

    // Two update requests in one frame with data changed between them
    run_cycles(0, 2, 32'hFF7F88C0, 4, 4, 1'b0);
    data = 16'h3456; lz = 1'b0; dp = 4'h0; update = 1'b1;
    run_cycles(2, 1, 32'hFF7F88C0, 4, 4, 1'b0);
    update = 1'b0;
    run_cycles(3, 5, 32'hFF7F88C0, 4, 4, 1'b0);
    data = 16'h789B; update = 1'b1;
    run_cycles(8, 1, 32'hFF7F88C0, 4, 4, 1'b0);
    update = 1'b0;
    run_cycles(9, 7, 32'hFF7F88C0, 4, 4, 1'b1);
    run_cycles(0, 16, 32'hF8809083, 4, 4, 1'b0);

    // Blink on digit 3 from a fresh reset
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst2");
    blink = 4'b0001;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    update = 1'b1;
    @(posedge clk); #1;
    chk("rst2_first_valid", 32'(valid), 32'h7);
    chk("rst2_first_value", 32'(value), 32'hC0);
    update = 1'b0;
    wait_fs(1'b1);
    for (int f = 1; f <= 6; f++) begin
      v = {24'hF88090, blink_off(f) ? 8'hFF : 8'h83};
      run_cycles(0, 16, v, 4, 4, 1'b0);
    end

    // Reset mid-slot with an update pending: no ack after release
    v = {24'hF88090, blink_off(7) ? 8'hFF : 8'h83};
    data = 16'h1111; update = 1'b1;
    run_cycles(0, 1, v, 4, 4, 1'b0);
    update = 1'b0;
    run_cycles(1, 2, v, 4, 4, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst3");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst3_first_valid", 32'(valid), 32'h7);
    chk("rst3_first_value", 32'(value), 32'hC0);
    saw_ack = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      saw_ack = saw_ack | ack;
    end
    chk("rst3_no_ack", 32'(saw_ack), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
